vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Frame-buffer port arbiter and pixel sequencer for the VGA display path. It owns the single-port frame-buffer RAM holding a 320x240 12-bit image and time-shares it between two users: the display, which fetches one pixel per 640x480 pixel period, and a write requester such as a CPU or camera. It divides `clk` into 4-cycle pixel slots, drives `pix_tick` to the timing generator, upscales QVGA to VGA by pixel doubling, and delays the syncs so they stay aligned with the colour outputs.

## Interface
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- ADDR_W, 17, RAM address width
- DATA_W, 12, RAM word width (R[11:8], G[7:4], B[3:0])
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- x_pixel  in  10  display column from the timing generator
- y_pixel  in  10  display row from the timing generator
- de  in  1  display-active flag from the timing generator
- h_sync_in, v_sync_in  in  1  raw syncs from the timing generator
- pix_tick  out  1  one-cycle strobe in slot 3; the timing generator advances on it
- h_sync, v_sync  out  1  syncs delayed 2 clk
- wr_req  in  1  write request; held until acknowledged
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  pulses in the cycle the write is granted
- wr_oob  out  1  sticky flag: a write address was ≥ FB_W*FB_H
- ram_en, ram_we  out  1  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read
- r_port, g_port, b_port  out  4  VGA colour outputs

## Operation
- **Slot counter:**
  - 2 bits; resets to 0 and increments every cycle, wrapping 3→0.
  - `pix_tick` = (slot==3), registered.
  - `x_pixel`, `y_pixel` and `de` are stable from slot 0 to slot 3.
- **Slot 0 with `de`=1 (display read):**
  - `ram_en`=1, `ram_we`=0.
  - `ram_addr` = (y_pixel>>1)*FB_W + (x_pixel>>1). The multiply is shift-add: (y<<8)+(y<<6) for FB_W=320.
  - `de` is captured into `de_q` in slot 0 only. A `de` change later in the same pixel is ignored.
- **Slot 1:** `ram_rdata` is latched into the pixel register if `de_q`=1; otherwise the pixel register is set to 0 (blanking).
- **Colour outputs:** `r_port`, `g_port`, `b_port` are driven from the pixel register.
- **Write grant:**
  - Granted in any cycle that is not a display-read cycle: slots 1–3 always, and slot 0 when `de`=0.
  - On grant: `wr_ack`=1 (combinational). `ram_en`=`ram_we`=1 and `ram_addr`/`ram_wdata` = `wr_addr`/`wr_data`, unless the address is out of range.
- **Out-of-range write:**
  - Condition: `wr_addr` ≥ FB_W*FB_H.
  - The write is still acknowledged, but `ram_en`=0, and `wr_oob` is set.
  - `wr_oob` clears only on reset.
- **Idle cycle:** no read and no write pending → `ram_en`=0.
- **Simultaneous display read and write request in slot 0:** the display wins. The write is granted in slot 1.
- **Write throughput:**
  - Continuous `wr_req` gets 3 writes per active pixel and 4 per blanking pixel.
  - The worst-case wait is 1 cycle.
- **Reset mid-operation:**
  - All registers clear immediately.
  - A pending write is not performed; the requester re-presents it.

## Timing
- **Reset values:** all outputs 0, slot counter 0, `wr_oob` 0.
- **Slot sequence after reset release:** the first rising edge is slot 0; `pix_tick` is first high in the 4th cycle.
- **Display latency:** read issued in slot 0, data in slot 1, colour visible from slot 2, held through slot 1 of the next pixel. This is 2 clk.
- **Sync alignment:**
  - `h_sync_in`/`v_sync_in` pass through a 2-stage register, so the syncs carry the same 2 clk latency as the colour.
  - The timing generator's sync edges change in slot 0, so `h_sync`/`v_sync` change in slot 2.
- **Write handshake:**
  - `wr_addr`/`wr_data` must be stable while `wr_req`=1.
  - The requester drops or advances `wr_req` in the cycle after `wr_ack`.

## Configuration
- **`VGA_FB_BORDER_EN`:**
  - Defined: when `de_q`=1 and the pixel is x=0, x=639, y=0 or y=479, the pixel register loads 12'hFFF instead of `ram_rdata`. This gives a white frame for monitor alignment.
  - Not defined: colour always comes from RAM.
  - Arbitration and RAM traffic are identical either way.

## Structure
- **Package `vga_pkg`:**
  - Constants: H_ACTIVE=640, V_ACTIVE=480, FB_W, FB_H, FB_DEPTH=FB_W*FB_H.
  - Typedefs: `rgb12_t` (packed struct r/g/b, 4 bits each) and the `slot_t` enum (SLOT_RD, SLOT_1, SLOT_2, SLOT_3).
- **Sub-module `vga_fb_addr`:** combinational QVGA address generator (x, y → addr). It is shared with the writer-side address checkers.

## Test plan
- Reset held low for 3 cycles → all outputs 0. After release, `pix_tick` is high in cycles 4, 8, 12.
- `de`=0, `wr_req`=1, `wr_addr`=0, `wr_data`=12'hF00 → `wr_ack`, `ram_en`, `ram_we` = 1 in that same cycle, `ram_addr`=0.
- `de`=1, x=0, y=0, `ram_rdata`=12'h0F0 in slot 1 → `r_port`=0, `g_port`=F, `b_port`=0 from slot 2 for 4 cycles.
- `de`=1, `wr_req` raised in slot 0 → no `wr_ack` in slot 0, `ram_we`=0. `wr_ack`=1 in slot 1.
- `de`=1, x=639, y=479 → `ram_addr`=76799 in slot 0.
- `wr_addr`=76800 → `wr_ack`=1, `ram_en`=0, `wr_oob`=1 and held until reset. With `VGA_FB_BORDER_EN` defined, x=0 gives output 12'hFFF regardless of `ram_rdata`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer path (QVGA store, VGA scan-out).
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned FB_W     = 320;
   localparam int unsigned FB_H     = 240;
   localparam int unsigned FB_DEPTH = FB_W * FB_H;
   localparam int unsigned ADDR_W   = 17;
   localparam int unsigned DATA_W   = 12;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef enum logic [1:0] {SLOT_RD, SLOT_1, SLOT_2, SLOT_3} slot_t;

   function automatic logic fb_addr_ok(input logic [ADDR_W-1:0] addr);
      return addr < ADDR_W'(FB_DEPTH);
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Write-requester handshake and frame-buffer RAM bus of the VGA arbiter.
interface vga_fb_arbiter_if;
   import vga_pkg::*;

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              wr_oob;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter side.
   modport master (
      input  wr_req, wr_addr, wr_data, ram_rdata,
      output wr_ack, wr_oob, ram_en, ram_we, ram_addr, ram_wdata
   );

   // Requester / RAM side.
   modport slave (
      output wr_req, wr_addr, wr_data, ram_rdata,
      input  wr_ack, wr_oob, ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/vga_fb_addr.sv
// QVGA frame-buffer address from a VGA coordinate: (y>>1)*FB_W + (x>>1).
module vga_fb_addr
   import vga_pkg::*;
(
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr
);

   logic [8:0] qx;
   logic [8:0] qy;
   logic       unused_lsb;

   // Shift-add form of qy*320 = qy*256 + qy*64.
   always_comb begin
      qx   = x[9:1];
      qy   = y[9:1];
      addr = ADDR_W'({qy, 8'b0}) + ADDR_W'({qy, 6'b0}) + ADDR_W'(qx);
   end

   // Pixel doubling discards the coordinate LSBs.
   assign unused_lsb = x[0] ^ y[0];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter and pixel sequencer: 4-cycle pixel slots, display read in slot 0.
// Optional VGA_FB_BORDER_EN forces a white one-pixel frame around the active area.
module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       x_pixel,
   input  logic [9:0]       y_pixel,
   input  logic             de,
   input  logic             h_sync_in,
   input  logic             v_sync_in,
   output logic             pix_tick,
   output logic             h_sync,
   output logic             v_sync,
   output logic [3:0]       r_port,
   output logic [3:0]       g_port,
   output logic [3:0]       b_port,
   vga_fb_arbiter_if.master bus
);

   slot_t             slot_q, slot_d;
   logic              pix_tick_q;
   logic              de_q;
   rgb12_t            pix_q, pix_d;
   logic [1:0]        hs_q, vs_q;
   logic              oob_q, oob_d;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_cycle;
   logic              grant;
   logic              wr_in_range;
   logic              border;

   vga_fb_addr u_addr (
      .x    (x_pixel),
      .y    (y_pixel),
      .addr (rd_addr)
   );

`ifdef VGA_FB_BORDER_EN
   assign border = (x_pixel == 10'd0) || (x_pixel == 10'(H_ACTIVE - 1)) ||
                   (y_pixel == 10'd0) || (y_pixel == 10'(V_ACTIVE - 1));
`else
   assign border = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q     <= SLOT_RD;
         pix_tick_q <= 1'b0;
         de_q       <= 1'b0;
         pix_q      <= '0;
         hs_q       <= '0;
         vs_q       <= '0;
         oob_q      <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         pix_tick_q <= (slot_d == SLOT_3);
         if (slot_q == SLOT_RD) de_q <= de;
         pix_q      <= pix_d;
         hs_q       <= {hs_q[0], h_sync_in};
         vs_q       <= {vs_q[0], v_sync_in};
         oob_q      <= oob_d;
      end
   end

   always_comb begin
      slot_d      = slot_t'(slot_q + 2'd1);
      // Gating with reset keeps a request presented during reset from reaching the RAM.
      rd_cycle    = reset && (slot_q == SLOT_RD) && de;
      grant       = reset && bus.wr_req && !rd_cycle;
      wr_in_range = fb_addr_ok(bus.wr_addr);

      pix_d = pix_q;
      if (slot_q == SLOT_1) begin
         if (!de_q)       pix_d = '0;
         else if (border) pix_d = '1;
         else             pix_d = rgb12_t'(bus.ram_rdata);
      end

      oob_d = oob_q | (grant & ~wr_in_range);

      bus.wr_ack    = grant;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (rd_cycle) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = rd_addr;
      end else if (grant && wr_in_range) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = 1'b1;
         bus.ram_addr  = bus.wr_addr;
         bus.ram_wdata = bus.wr_data;
      end
   end

   assign pix_tick   = pix_tick_q;
   assign h_sync     = hs_q[1];
   assign v_sync     = vs_q[1];
   assign r_port     = pix_q.r;
   assign g_port     = pix_q.g;
   assign b_port     = pix_q.b;
   assign bus.wr_oob = oob_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: slot timing, display fetch, write arbitration, OOB flag.
module tb_vga_fb_arbiter;
   import vga_pkg::*;

`ifdef VGA_FB_BORDER_EN
   localparam logic [11:0] EXP_CORNER = 12'hFFF;
`else
   localparam logic [11:0] EXP_CORNER = 12'h0F0;
`endif

   logic       clk;
   logic       reset;
   logic [9:0] x_pixel;
   logic [9:0] y_pixel;
   logic       de;
   logic       h_sync_in;
   logic       v_sync_in;
   logic       pix_tick;
   logic       h_sync;
   logic       v_sync;
   logic [3:0] r_port;
   logic [3:0] g_port;
   logic [3:0] b_port;

   int n_vec = 0;
   int n_err = 0;

   vga_fb_arbiter_if bus ();

   vga_fb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .x_pixel   (x_pixel),
      .y_pixel   (y_pixel),
      .de        (de),
      .h_sync_in (h_sync_in),
      .v_sync_in (v_sync_in),
      .pix_tick  (pix_tick),
      .h_sync    (h_sync),
      .v_sync    (v_sync),
      .r_port    (r_port),
      .g_port    (g_port),
      .b_port    (b_port),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b0;
      x_pixel       = '0;
      y_pixel       = '0;
      de            = 1'b0;
      h_sync_in     = 1'b1;
      v_sync_in     = 1'b1;
      bus.wr_req    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.ram_rdata = 12'hABC;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_tick", pix_tick, 0);
      chk("rst_h_sync", h_sync, 0);
      chk("rst_v_sync", v_sync, 0);
      chk("rst_colour", {r_port, g_port, b_port}, 0);
      chk("rst_wr_ack", bus.wr_ack, 0);
      chk("rst_ram_en", bus.ram_en, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_wr_oob", bus.wr_oob, 0);
      h_sync_in = 1'b0;
      v_sync_in = 1'b0;
      @(negedge clk) reset = 1'b1;

      // pix_tick high in cycles 4, 8, 12 after release
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("pix_tick_c%0d", k + 1), pix_tick, (k % 4 == 3) ? 1 : 0);
      end

      // Slot 0, blanking: write granted immediately
      bus.wr_req  = 1'b1;
      bus.wr_addr = '0;
      bus.wr_data = 12'hF00;
      #1;
      chk("wr0_ack", bus.wr_ack, 1);
      chk("wr0_en", bus.ram_en, 1);
      chk("wr0_we", bus.ram_we, 1);
      chk("wr0_addr", bus.ram_addr, 0);
      chk("wr0_wdata", bus.ram_wdata, 12'hF00);
      tick();  // slot 1
      bus.wr_addr = 17'd5;
      bus.wr_data = 12'h0AB;
      #1;
      chk("wr1_ack", bus.wr_ack, 1);
      chk("wr1_addr", bus.ram_addr, 5);
      chk("wr1_wdata", bus.ram_wdata, 12'h0AB);
      tick();  // slot 2
      bus.wr_req = 1'b0;
      #1;
      chk("idle_en", bus.ram_en, 0);
      chk("idle_ack", bus.wr_ack, 0);
      tick();
      tick();  // slot 0

      // Display fetch at (0,0)
      de        = 1'b1;
      x_pixel   = 10'd0;
      y_pixel   = 10'd0;
      bus.ram_rdata = 12'h000;
      #1;
      chk("rd0_en", bus.ram_en, 1);
      chk("rd0_we", bus.ram_we, 0);
      chk("rd0_addr", bus.ram_addr, 0);
      tick();  // slot 1
      bus.ram_rdata = 12'h0F0;
      #1;
      tick();  // slot 2
      bus.ram_rdata = 12'h5A5;
      #1;
      chk("col_s2", {r_port, g_port, b_port}, EXP_CORNER);
      tick();  // slot 3
      chk("col_s3", {r_port, g_port, b_port}, EXP_CORNER);
      tick();  // slot 0, next pixel (2,2)
      x_pixel = 10'd2;
      y_pixel = 10'd2;
      #1;
      chk("col_s0", {r_port, g_port, b_port}, EXP_CORNER);
      chk("rd1_addr", bus.ram_addr, 321);
      tick();  // slot 1
      bus.ram_rdata = 12'h00F;
      #1;
      chk("col_s1", {r_port, g_port, b_port}, EXP_CORNER);
      tick();  // slot 2
      chk("col_next", {r_port, g_port, b_port}, 12'h00F);
      tick();
      tick();  // slot 0

      // Display read beats a write in slot 0; write goes in slot 1
      x_pixel     = 10'd4;
      y_pixel     = 10'd4;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 17'd100;
      bus.wr_data = 12'h123;
      #1;
      chk("col_ack_s0", bus.wr_ack, 0);
      chk("col_we_s0", bus.ram_we, 0);
      chk("col_en_s0", bus.ram_en, 1);
      chk("col_addr_s0", bus.ram_addr, 642);
      tick();  // slot 1
      bus.ram_rdata = 12'h456;
      #1;
      chk("col_ack_s1", bus.wr_ack, 1);
      chk("col_we_s1", bus.ram_we, 1);
      chk("col_addr_s1", bus.ram_addr, 100);
      chk("col_wdata_s1", bus.ram_wdata, 12'h123);
      tick();  // slot 2
      bus.wr_req = 1'b0;
      #1;
      chk("col_pix", {r_port, g_port, b_port}, 12'h456);
      tick();
      tick();  // slot 0

      // de rising after slot 0 is ignored; syncs delayed 2 clk
      de        = 1'b0;
      x_pixel   = 10'd6;
      y_pixel   = 10'd4;
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;
      #1;
      chk("blank_en", bus.ram_en, 0);
      tick();  // slot 1
      de            = 1'b1;
      bus.ram_rdata = 12'h777;
      #1;
      chk("hs_s1", h_sync, 0);
      tick();  // slot 2
      chk("blank_pix", {r_port, g_port, b_port}, 0);
      chk("hs_s2", h_sync, 1);
      chk("vs_s2", v_sync, 1);
      tick();
      tick();  // slot 0

      // Bottom-right pixel address
      h_sync_in = 1'b0;
      v_sync_in = 1'b0;
      x_pixel   = 10'd639;
      y_pixel   = 10'd479;
      #1;
      chk("rd_last_addr", bus.ram_addr, 76799);
      tick();  // slot 1

      // Last in-range write, then out-of-range write
      bus.wr_req  = 1'b1;
      bus.wr_addr = 17'd76799;
      bus.wr_data = 12'h321;
      #1;
      chk("wr_last_en", bus.ram_en, 1);
      chk("wr_last_ack", bus.wr_ack, 1);
      tick();  // slot 2
      chk("oob_clear", bus.wr_oob, 0);
      bus.wr_addr = 17'd76800;
      #1;
      chk("oob_ack", bus.wr_ack, 1);
      chk("oob_en", bus.ram_en, 0);
      tick();  // slot 3
      bus.wr_req = 1'b0;
      #1;
      chk("oob_set", bus.wr_oob, 1);
      repeat (5) tick();
      chk("oob_held", bus.wr_oob, 1);

      // Reset mid-operation with a write pending
      de          = 1'b0;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 17'd10;
      @(negedge clk) reset = 1'b0;
      #1;
      chk("mid_rst_oob", bus.wr_oob, 0);
      chk("mid_rst_ack", bus.wr_ack, 0);
      chk("mid_rst_en", bus.ram_en, 0);
      chk("mid_rst_pix", {r_port, g_port, b_port}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
